// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the byte-wide instruction ROM and the core.
interface instr_fetch_ctrl_if;
  logic        start;
  logic [7:0]  rom_address;
  logic [7:0]  data_from_rom;
  logic [31:0] instruction_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    input  data_from_rom,
    input  instr_ready,
    input  redirect,
    input  redirect_addr,
    output rom_address,
    output instruction_in,
    output instr_valid,
    output busy,
    output done
  );

  modport slave (
    output start,
    output data_from_rom,
    output instr_ready,
    output redirect,
    output redirect_addr,
    input  rom_address,
    input  instruction_in,
    input  instr_valid,
    input  busy,
    input  done
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Assembles 32-bit little-endian instructions from a synchronous byte ROM and hands them to the
// core over a valid/ready handshake, with jump redirects and a halt word.
module instr_fetch_ctrl #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StHalted} state_e;

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [1:0]  issue_cnt_q;
  logic [2:0]  cap_cnt_q;
  logic [23:0] asm_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  redirect_pc;
  logic        unused_redirect_lsbs;

  assign redirect_pc          = {bus.redirect_addr[7:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_addr[1:0];

  // issue_cnt wraps back to 0 in the final capture cycle, so the address falls back to pc there.
  assign bus.rom_address    = (state_q == StFetch) ? pc_q + {6'd0, issue_cnt_q} : pc_q;
  assign bus.instruction_in = instr_q;
  assign bus.instr_valid    = valid_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      asm_q       <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHalted: begin
          if (bus.start) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        StFetch: begin
          if (bus.redirect) begin
            // Bytes already in the ROM pipeline are dropped: capture restarts from count 0.
            pc_q        <= redirect_pc;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
          end else begin
            issue_cnt_q <= issue_cnt_q + 2'd1;
            cap_cnt_q   <= cap_cnt_q + 3'd1;
            case (cap_cnt_q)
              3'd1: asm_q[7:0]   <= bus.data_from_rom;
              3'd2: asm_q[15:8]  <= bus.data_from_rom;
              3'd3: asm_q[23:16] <= bus.data_from_rom;
              3'd4: begin
                instr_q <= {bus.data_from_rom, asm_q};
                valid_q <= 1'b1;
                state_q <= StWait;
              end
              default: ;
            endcase
          end
        end
        StWait: begin
          if (bus.redirect) begin
            // A simultaneous transfer still completes, but never halts and never advances pc.
            state_q     <= StFetch;
            pc_q        <= redirect_pc;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            valid_q     <= 1'b0;
          end else if (bus.instr_ready) begin
            pc_q        <= pc_q + 8'd4;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            valid_q     <= 1'b0;
            if (instr_q == HALT_WORD) begin
              state_q <= StHalted;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table, hand-written corner sequences and random
// stimulus checked against a word-level behavioural model.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;
  localparam int MIdle  = 0;
  localparam int MFetch = 1;
  localparam int MWait  = 2;
  localparam int MHalt  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(.HALT_WORD(HaltWord)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  always @(posedge clk) bus.data_from_rom <= rom[bus.rom_address];

  int vectors = 0;
  int miscompares = 0;

  // Model: which spec state we are in, the word address, and cycles spent since FETCH entry.
  int m_mode, m_pc, m_age;

  typedef struct {
    logic        start;
    logic        ready;
    logic        redirect;
    logic [7:0]  raddr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [7:0]  exp_addr;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;
  vec_t vecs [12];

  function automatic logic [31:0] rom_word(input int a);
    return {rom[(a + 3) % 256], rom[(a + 2) % 256], rom[(a + 1) % 256], rom[a % 256]};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic st, input logic rdy, input logic rdr,
                            input logic [7:0] ra);
    case (m_mode)
      MIdle, MHalt: if (st) begin
        m_mode = MFetch; m_pc = 0; m_age = 0;
      end
      MFetch: begin
        if (rdr) begin
          m_pc = int'(ra) & 'hFC; m_age = 0;
        end else if (m_age == 4) m_mode = MWait;
        else m_age++;
      end
      MWait: begin
        if (rdr) begin
          m_mode = MFetch; m_pc = int'(ra) & 'hFC; m_age = 0;
        end else if (rdy) begin
          if (rom_word(m_pc) == HaltWord) m_mode = MHalt;
          else begin
            m_mode = MFetch; m_age = 0;
          end
          m_pc = (m_pc + 4) % 256;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_model();
    cmp("model.valid", 32'(bus.instr_valid), 32'(m_mode == MWait));
    cmp("model.busy", 32'(bus.busy), 32'(m_mode == MFetch || m_mode == MWait));
    cmp("model.done", 32'(bus.done), 32'(m_mode == MHalt));
    if (m_mode == MWait) cmp("model.instr", bus.instruction_in, rom_word(m_pc));
    if (m_mode != MHalt)
      cmp("model.addr", 32'(bus.rom_address),
          (m_mode == MFetch && m_age < 4) ? 32'((m_pc + m_age) % 256) : 32'(m_pc));
  endtask

  // Called at a falling edge: drive inputs, cross one rising edge, check at the next falling edge.
  task automatic cycle(input logic st, input logic rdy, input logic rdr, input logic [7:0] ra);
    bus.start = st; bus.instr_ready = rdy; bus.redirect = rdr; bus.redirect_addr = ra;
    @(posedge clk);
    model_step(st, rdy, rdr, ra);
    @(negedge clk);
    check_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, ".valid"}, 32'(bus.instr_valid), 32'd0);
    cmp({tag, ".busy"}, 32'(bus.busy), 32'd0);
    cmp({tag, ".done"}, 32'(bus.done), 32'd0);
    cmp({tag, ".addr"}, 32'(bus.rom_address), 32'd0);
    cmp({tag, ".instr"}, bus.instruction_in, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0; bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_addr = 8'h00;
    m_mode = MIdle; m_pc = 0; m_age = 0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h01, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h02, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h03, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h00, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'h44332211,  8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h04, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h05, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h06, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h07, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h04, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h88776655,  8'h04, 1'b1, 1'b0};

    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 7 + 3) % 256);
    for (int i = 0; i < 8; i++) rom[i] = 8'((i + 1) * 8'h11);
    rom[8'h10] = 8'hDE; rom[8'h11] = 8'hAD; rom[8'h12] = 8'hBE; rom[8'h13] = 8'hEF;
    for (int i = 8'h20; i < 8'h24; i++) rom[i] = 8'hFF;
    rom[8'hFC] = 8'h01; rom[8'hFD] = 8'h02; rom[8'hFE] = 8'h03; rom[8'hFF] = 8'h04;

    do_reset();

    // Redirect is ignored in IDLE.
    cycle(1'b0, 1'b1, 1'b1, 8'h40);
    cmp("idle_redirect.addr", 32'(bus.rom_address), 32'h00);
    cmp("idle_redirect.busy", 32'(bus.busy), 32'd0);

    // Two back-to-back instructions with ready high, 6-cycle spacing; start in FETCH ignored.
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].start, vecs[i].ready, vecs[i].redirect, vecs[i].raddr);
      cmp($sformatf("tbl%0d.valid", i), 32'(bus.instr_valid), 32'(vecs[i].exp_valid));
      cmp($sformatf("tbl%0d.addr", i), 32'(bus.rom_address), 32'(vecs[i].exp_addr));
      cmp($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      cmp($sformatf("tbl%0d.done", i), 32'(bus.done), 32'(vecs[i].exp_done));
      if (vecs[i].exp_valid) cmp($sformatf("tbl%0d.instr", i), bus.instruction_in,
                                 vecs[i].exp_instr);
    end

    // Core stalls for 10 cycles: word, valid and address hold.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cmp("stall.valid", 32'(bus.instr_valid), 32'd1);
      cmp("stall.instr", bus.instruction_in, 32'h88776655);
      cmp("stall.addr", 32'(bus.rom_address), 32'h04);
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cmp("advance.addr", 32'(bus.rom_address), 32'h08);

    // Redirect in FETCH cycle 2 to 8'h13 lands on 8'h10; the partial word at 8'h08 is lost.
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cmp("fetch2.addr", 32'(bus.rom_address), 32'h0A);
    cycle(1'b0, 1'b0, 1'b1, 8'h13);
    cmp("redirect.addr", 32'(bus.rom_address), 32'h10);
    cmp("redirect.valid", 32'(bus.instr_valid), 32'd0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cmp("redirect_t4.valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cmp("redirect_t5.valid", 32'(bus.instr_valid), 32'd1);
    cmp("redirect_t5.instr", bus.instruction_in, 32'hEFBEADDE);

    // Redirect beats a halt-word transfer in the same cycle.
    cycle(1'b0, 1'b0, 1'b1, 8'h20);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cmp("haltword.instr", bus.instruction_in, HaltWord);
    cycle(1'b0, 1'b1, 1'b1, 8'h31);
    cmp("redir_over_halt.done", 32'(bus.done), 32'd0);
    cmp("redir_over_halt.busy", 32'(bus.busy), 32'd1);
    cmp("redir_over_halt.addr", 32'(bus.rom_address), 32'h30);

    // Halt word at 8'h08 ends the program; start restarts at 8'h00.
    do_reset();
    for (int i = 8; i < 12; i++) rom[i] = 8'hFF;
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (17) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cmp("halt_t17.instr", bus.instruction_in, HaltWord);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cmp("halted.done", 32'(bus.done), 32'd1);
    cmp("halted.busy", 32'(bus.busy), 32'd0);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 8'h50);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cmp("restart.addr", 32'(bus.rom_address), 32'h00);
    cmp("restart.done", 32'(bus.done), 32'd0);
    cmp("restart.busy", 32'(bus.busy), 32'd1);

    // pc 8'hFC + 4 wraps to 8'h00.
    cycle(1'b0, 1'b1, 1'b1, 8'hFE);
    cmp("wrap_entry.addr", 32'(bus.rom_address), 32'hFC);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cmp("wrap.instr", bus.instruction_in, 32'h04030201);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cmp("wrap.addr", 32'(bus.rom_address), 32'h00);

    // Asynchronous reset in WAIT, away from any clock edge.
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cmp("prereset.valid", 32'(bus.instr_valid), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    m_mode = MIdle; m_pc = 0; m_age = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cmp("post_reset.valid", 32'(bus.instr_valid), 32'd0);

    // Random ROM image with a few halt words, random control traffic.
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      int a;
      a = int'($urandom_range(0, 63)) * 4;
      for (int j = 0; j < 4; j++) rom[a + j] = 8'hFF;
    end
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom % 8 == 0), 1'($urandom % 3 != 0), 1'($urandom % 16 == 0),
            8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, the instruction word that terminates the program.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; state clears while reset=0.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins fetching at ROM address 8'h00.
REQ-005 SHALL have port rom_address  output  8  byte address driven to the instruction ROM.
REQ-006 SHALL have port data_from_rom  input  8  ROM byte, valid one cycle after its rom_address.
REQ-007 SHALL have port instruction_in  output  32  assembled instruction presented to the core.
REQ-008 SHALL have port instr_valid  output  1  instruction_in holds a complete instruction.
REQ-009 SHALL have port instr_ready  input  1  the core accepts instruction_in this cycle.
REQ-010 SHALL have port redirect  input  1  one-cycle pulse that changes the fetch address (jump or branch).
REQ-011 SHALL have port redirect_addr  input  8  jump target; bits [1:0] are ignored and forced to 0.
REQ-012 SHALL have port busy  output  1  high in FETCH and WAIT states.
REQ-013 SHALL have port done  output  1  high in HALTED state.

Function
REQ-014 SHALL implement states IDLE, FETCH, WAIT and HALTED, held in an 8-bit word-aligned pc, a 2-bit issue counter and a 3-bit capture counter.
REQ-015 SHALL move from IDLE to FETCH on start, with pc=8'h00; start in FETCH or WAIT SHALL be ignored.
REQ-016 SHALL drive rom_address=pc+k in FETCH cycle k (k=0..3), and rom_address=pc in all other states.
REQ-017 SHALL capture the byte from data_from_rom one cycle after each address, little-endian: byte at pc+0 into bits [7:0], pc+3 into bits [31:24].
REQ-018 SHALL enter WAIT with instr_valid=1 in the 6th cycle after FETCH entry (cycle t5, FETCH entered at t0).
REQ-019 SHALL hold instruction_in and instr_valid stable in WAIT while instr_ready=0.
REQ-020 SHALL treat instr_valid=1 with instr_ready=1 as a transfer: instr_valid drops next cycle, pc advances by 4 and FETCH is re-entered.
REQ-021 SHALL wrap pc 8'hFC+4 to 8'h00 with no error indication.
REQ-022 SHALL, when HALT_WORD is transferred, go to HALTED with done=1, busy=0 and no further ROM fetches; start in HALTED SHALL restart at pc=8'h00 and clear done.
REQ-023 SHALL, on redirect in FETCH or WAIT, discard every in-flight byte, drop instr_valid next cycle, set pc={redirect_addr[7:2],2'b00} and restart FETCH next cycle.
REQ-024 SHALL give redirect priority over transfer in the same cycle: the transfer counts as completed, but the next fetch uses the redirect target and HALT_WORD does not halt.
REQ-025 SHALL ignore redirect in IDLE and HALTED.
REQ-026 SHALL produce an instr_valid=1 to instr_valid=1 spacing of exactly 6 cycles with instr_ready tied high.

Reset
REQ-027 SHALL, while reset=0, force state=IDLE, pc=8'h00, rom_address=8'h00, instruction_in=32'h0, instr_valid=0, busy=0 and done=0, independent of clk.
REQ-028 SHALL, on reset mid-fetch or mid-WAIT, abandon all partial data; no instruction is presented after reset releases until start.

Verification
REQ-029 SHALL pass: ROM bytes 00..07 = 11,22,33,44,55,66,77,88, start, instr_ready=1 -> instruction_in=32'h44332211 at t5, then 32'h88776655 six cycles later.
REQ-030 SHALL pass: instr_ready held 0 for 10 cycles in WAIT -> instruction_in and instr_valid stable, rom_address=pc, no new fetch.
REQ-031 SHALL pass: redirect with redirect_addr=8'h13 in FETCH cycle 2 -> rom_address=8'h10 next cycle, old partial word never presented.
REQ-032 SHALL pass: word at 8'h08 = FFFFFFFF -> after its transfer done=1, busy=0; start -> fetch resumes at 8'h00 and done=0.
REQ-033 SHALL pass: pc=8'hFC transferred -> next fetch starts at rom_address=8'h00.
REQ-034 SHALL pass: reset=0 asserted mid-WAIT, asynchronous to clk -> instr_valid=0 immediately, with all outputs at their reset values.
